// File: rtl/serial_tx_port_pkg.sv
// Shared encodings for the serial transmit port: FSM states, register offsets and
// status-word bit positions.
package serial_tx_port_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned RegTxdata = 0;
  localparam int unsigned RegStatus = 1;

  localparam int unsigned StatFull     = 0;
  localparam int unsigned StatEmpty    = 1;
  localparam int unsigned StatBusy     = 2;
  localparam int unsigned StatOvf      = 3;
  localparam int unsigned StatCountLsb = 4;
  localparam int unsigned StatCountW   = 7;

endpackage

// File: rtl/serial_tx_port_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/serial_tx_port.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a FIFO, STATUS reports
// FIFO/FSM state combinationally during a load strobe.
module serial_tx_port
  import serial_tx_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0020,
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        mem_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_oe,
  output logic        tx
);

  localparam logic [31:0] TxdataAddr = BASE_ADDR + 32'(RegTxdata);
  localparam logic [31:0] StatusAddr = BASE_ADDR + 32'(RegStatus);
  localparam logic [15:0] BaudMax    = 16'(CLK_DIV - 1);

  logic                   sel_data, sel_stat, push, pop, ovf_set, ovf_clr;
  logic                   fifo_full, fifo_empty;
  logic [7:0]             fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   ovf_q;
  tx_state_e              state_q;
  logic [15:0]            baud_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   tx_q;
  logic                   unused_wdata;

  assign unused_wdata = ^{d_wdata[31:8]};

  assign sel_data = strobe && (d_addr == TxdataAddr);
  assign sel_stat = strobe && (d_addr == StatusAddr);
  assign push     = sel_data && mem_rw;
  assign ovf_clr  = sel_stat && mem_rw && d_wdata[3];
  // Full FIFO still accepts a byte when the FSM pops in the same cycle.
  assign ovf_set  = push && fifo_full && !pop;
  assign pop      = !fifo_empty &&
                    ((state_q == StIdle) || ((state_q == StStop) && (baud_q == '0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (d_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign d_oe = (sel_data || sel_stat) && !mem_rw;
  assign tx   = tx_q;

  always_comb begin
    d_rdata = '0;
    if (sel_stat && !mem_rw) begin
      d_rdata[StatFull]                        = fifo_full;
      d_rdata[StatEmpty]                       = fifo_empty;
      d_rdata[StatBusy]                        = (state_q != StIdle);
      d_rdata[StatOvf]                         = ovf_q;
      d_rdata[StatCountLsb +: StatCountW]      = StatCountW'(fifo_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // tx follows the state one cycle late, so every bit period stays CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StStart: tx_q <= 1'b0;
        StData:  tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            baud_q  <= BaudMax;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_q == '0) begin
            baud_q    <= BaudMax;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        StData: begin
          if (baud_q == '0) begin
            baud_q  <= BaudMax;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        StStop: begin
          if (baud_q == '0) begin
            if (!fifo_empty) begin
              shift_q <= fifo_rdata;
              baud_q  <= BaudMax;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_port.sv
// Directed bench for serial_tx_port with CLK_DIV=4, DEPTH=4, BASE_ADDR=0x20.
module tb_serial_tx_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic        mem_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_oe;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx_port #(
    .BASE_ADDR (32'h0000_0020),
    .CLK_DIV   (4),
    .DEPTH     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .strobe  (strobe),
    .mem_rw  (mem_rw),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_oe    (d_oe),
    .tx      (tx)
  );

  // Expected line level k cycles after tx falls for a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k < 4)  return 1'b0;
    if (k < 36) return b[(k - 4) / 4];
    return 1'b1;
  endfunction

  task automatic bus_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b1; d_addr = addr; d_wdata = data;
    @(posedge clk);
    #1;
    strobe = 1'b0; mem_rw = 1'b0;
  endtask

  task automatic bus_load(input logic [31:0] addr, output logic [31:0] data,
                          output logic oe);
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b0; d_addr = addr;
    #1;
    data = d_rdata;
    oe   = d_oe;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        oe;
    reset = 1'b1; strobe = 1'b0; mem_rw = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (d_oe !== 1'b0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus_idle: got oe=%b rdata=%h want 0/0", d_oe, d_rdata);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx[%0d]: got %b want 1", i, tx); end
    end
    bus_load(32'h21, rd, oe);
    checks++;
    if (rd !== 32'h0000_0002 || oe !== 1'b1) begin
      errors++; $display("FAIL reset_status: got %h oe=%b want 00000002 oe=1", rd, oe);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] b = 8'hA5;
    bus_store(32'h20, 32'h0000_01A5);
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_latency: E+1 tx=%b want 1", tx); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== frame_bit(b, k)) begin
        errors++; $display("FAIL single_frame[%0d]: got %b want %b", k, tx, frame_bit(b, k));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_after: got %b want 1", tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic       exp;
    int         j;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
    repeat (5) @(posedge clk);
    for (int i = 0; i < 215; i++) begin
      @(negedge clk);
      if (i < 6) begin
        strobe = 1'b1; mem_rw = 1'b1; d_addr = 32'h20; d_wdata = {24'hABCDEF, bytes[i]};
      end else if (i == 6) begin
        strobe = 1'b1; mem_rw = 1'b0; d_addr = 32'h21;
        #1;
        checks++;
        if (d_rdata !== 32'h0000_004D || d_oe !== 1'b1) begin
          errors++; $display("FAIL b2b_status: got %h oe=%b want 0000004d oe=1", d_rdata, d_oe);
        end
      end else begin
        strobe = 1'b0; mem_rw = 1'b0;
      end
      @(posedge clk); #1;
      j = i - 2;
      if (j < 0 || j >= 200) exp = 1'b1;
      else                   exp = frame_bit(bytes[j / 40], j % 40);
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, tx, exp); end
    end
    strobe = 1'b0;
  endtask

  task automatic test_overflow_clear();
    logic [31:0] rd;
    logic        oe;
    bus_load(32'h21, rd, oe);
    checks++;
    if (rd !== 32'h0000_000A) begin
      errors++; $display("FAIL ovf_held: got %h want 0000000a", rd);
    end
    bus_store(32'h21, 32'hFFFF_FFF7);
    bus_load(32'h21, rd, oe);
    checks++;
    if (rd !== 32'h0000_000A) begin
      errors++; $display("FAIL ovf_no_clear: got %h want 0000000a", rd);
    end
    bus_store(32'h21, 32'h0000_0008);
    bus_load(32'h21, rd, oe);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++; $display("FAIL ovf_clear: got %h want 00000002", rd);
    end
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    logic        oe;
    bus_load(32'h22, rd, oe);
    checks++;
    if (oe !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL decode_22: got oe=%b rdata=%h want 0/0", oe, rd);
    end
    bus_load(32'h1F, rd, oe);
    checks++;
    if (oe !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL decode_1f: got oe=%b rdata=%h want 0/0", oe, rd);
    end
    bus_load(32'h20, rd, oe);
    checks++;
    if (oe !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL decode_txdata_load: got oe=%b rdata=%h want 1/0", oe, rd);
    end
    bus_store(32'h40, 32'h0000_0055);
    bus_load(32'h21, rd, oe);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++; $display("FAIL decode_store_40: got %h want 00000002", rd);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL decode_tx[%0d]: got %b want 1", i, tx); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    logic        oe;
    bus_store(32'h20, 32'h0000_0000);
    bus_store(32'h20, 32'h0000_0000);
    // Now 1 ns after edge E+1; data bit 3 occupies E+18..E+21.
    repeat (17) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3: got %b want 0", tx); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b want 1", tx); end
    @(negedge clk); reset = 1'b0;
    bus_load(32'h21, rd, oe);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++; $display("FAIL midframe_status: got %h want 00000002", rd);
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL midframe_quiet[%0d]: got %b want 1", i, tx); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow_clear();
    test_decode();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
